instruction_fetch: RTL
======================

# instruction_fetch

Fetch unit sitting on the read side of the program counter: it samples the current PC, performs a handshaked read of instruction memory, and holds the returned instruction for the decoder until accepted. It also detects misaligned PCs, memory access errors and memory timeouts, and reports them as fault outputs for the control unit. One fetch is in flight at a time; control decides when to start each fetch and when to update the PC.

## Interface
- `RESET_INSTRUCTION`, default 32'h00000013 (NOP), value driven on `instruction` after reset.
- `TIMEOUT_CYCLES`, default 255, cycles `memRequest` may stay high without `memReady` before a timeout fault (1..255).
- `clock` in 1: sole clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `pcOfInstruction` in 32: current PC from the program counter.
- `fetchStart` in 1: request a fetch at `pcOfInstruction`.
- `memAddress` out 32: read address, stable while `memRequest` is high.
- `memRequest` out 1: read request.
- `memReady` in 1: memory completes the read this cycle.
- `memReadData` in 32: read data, valid when `memReady` is high.
- `memError` in 1: access error, qualified by `memReady`.
- `instruction` out 32: fetched instruction.
- `instructionValid` out 1: `instruction` holds a new, unaccepted instruction.
- `instructionReady` in 1: decoder accepts `instruction` this cycle.
- `busy` out 1: high in REQUEST or HOLD.
- `fault` out 1: sticky fault indication.
- `faultCause` out 2: 00 none, 01 misaligned, 10 access error, 11 timeout.
- `faultAddress` out 32: PC of the faulting fetch.

## Operation
- States: IDLE, REQUEST, HOLD, FAULT.
- IDLE: if `fetchStart` and `pcOfInstruction[1:0]==0`, latch PC into `memAddress` and go to REQUEST. If `fetchStart` with a misaligned PC, go to FAULT with cause 01 and `faultAddress`=PC; `memRequest` is never raised.
- REQUEST: `memRequest`=1. A transfer occurs in a cycle with `memRequest & memReady`.
  - Transfer with `memError`=0: latch `memReadData` into `instruction`, go to HOLD.
  - Transfer with `memError`=1: go to FAULT with cause 10. `instruction` is unchanged.
  - No transfer: increment an 8-bit wait counter. When it reaches `TIMEOUT_CYCLES`, go to FAULT with cause 11. The counter clears on entry to REQUEST.
- HOLD: `instructionValid`=1 and `instruction` is held.
  - `instructionReady`=1: if `fetchStart` is also high, start the next fetch immediately. This follows the IDLE rules, including the misaligned check. Otherwise go to IDLE.
- FAULT: `fault`=1; `faultCause` and `faultAddress` are held. `fetchStart` clears the fault and is handled by the IDLE rules in the same cycle, so the next state may be REQUEST or FAULT again.
- `fetchStart` is ignored in REQUEST, and in HOLD without `instructionReady`.
- `memReady` and `memError` are ignored outside REQUEST.
- `instructionReady` is ignored outside HOLD.
- `faultCause`=00 and `faultAddress`=0 whenever the state is not FAULT.

## Timing
- Reset values: state IDLE, `memRequest`=0, `memAddress`=0, `instruction`=`RESET_INSTRUCTION`, `instructionValid`=0, `busy`=0, `fault`=0, `faultCause`=00, `faultAddress`=0, wait counter 0.
- Reset asserted mid-fetch (REQUEST or HOLD) returns to IDLE at the next edge. A late `memReady` after reset is ignored.
- Minimum latency with a zero-wait memory: `fetchStart` at cycle N, `memRequest` at N+1, `instructionValid` at N+2.
- Back-to-back throughput: one instruction per 2 cycles.
- Outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- Misaligned fault: `fault`=1 one cycle after `fetchStart`.
- Timeout: with no `memReady`, `memRequest` stays high for exactly `TIMEOUT_CYCLES` cycles, and `fault` rises on the next cycle.
- `pcOfInstruction` is sampled only in the `fetchStart` cycle. Later PC changes do not affect `memAddress`.

## Test plan
- After reset, PC=0x00000100, `fetchStart` pulse, `memReady`=1 with data 0xDEADBEEF on the first request cycle -> `memAddress`=0x100 at N+1; `instruction`=0xDEADBEEF with `instructionValid` at N+2; with `instructionReady` high, state returns to IDLE at N+3.
- PC=0x00000102 with `fetchStart` -> no `memRequest`; `fault`=1, `faultCause`=01, `faultAddress`=0x102. Then PC=0x104 with `fetchStart` -> fault clears and a normal fetch proceeds.
- Memory holds `memReady` low for 3 cycles, then responds with `memError`=1 -> `faultCause`=10; `instruction` still equals `RESET_INSTRUCTION`.
- `TIMEOUT_CYCLES`=4, memory never ready -> `memRequest` high exactly 4 cycles, then `faultCause`=11.
- Decoder holds `instructionReady` low for 5 cycles -> `instruction` stable and `fetchStart` ignored. Then `instructionReady` and `fetchStart` are both asserted with PC=0x108 -> `memRequest` with `memAddress`=0x108 on the next cycle.
- `reset` asserted during REQUEST, while `memReady` rises in the same cycle -> all outputs take their reset values next cycle; `instructionValid` stays 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Read side of the program counter. On fetchStart the current PC is sampled,
// checked for word alignment and, if aligned, read from instruction memory
// through a request/ready handshake. The returned word is held for the
// decoder until it is accepted. Misaligned PCs, memory access errors and
// memory timeouts park the unit in a sticky fault state that reports the
// cause and the PC of the faulting fetch; the next fetchStart clears it.
// Only one fetch is ever outstanding.
//
// Parameters
//   RESET_INSTRUCTION  value shown on instruction after reset (NOP)
//   TIMEOUT_CYCLES     request cycles without memReady before a timeout (1..255)
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   pcOfInstruction     PC to fetch, sampled only in the fetchStart cycle
//   fetchStart          start a fetch (IDLE, FAULT, or HOLD with ready)
//   memAddress/Request  read request, address stable while request is high
//   memReady/ReadData/  read completion, data and error, only honoured
//   memError              while the request is high
//   instruction/Valid   held instruction and its unaccepted flag
//   instructionReady    decoder accepts the held instruction
//   busy                a fetch is in REQUEST or HOLD
//   fault/faultCause/   sticky fault, cause (01 misaligned, 10 access error,
//   faultAddress          11 timeout) and PC; cause/address are 0 otherwise
//
// Every output is either a register or a pure decode of the state register,
// so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_INSTRUCTION = 32'h00000013,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pcOfInstruction,
  input  logic        fetchStart,
  output logic [31:0] memAddress,
  output logic        memRequest,
  input  logic        memReady,
  input  logic [31:0] memReadData,
  input  logic        memError,
  output logic [31:0] instruction,
  output logic        instructionValid,
  input  logic        instructionReady,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  faultCause,
  output logic [31:0] faultAddress
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_HOLD    = 2'd2,
    S_FAULT   = 2'd3
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ACCESS   = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  // The wait counter is 8 bits wide; the limit is the count reached after
  // the last allowed request cycle, so the request is high TIMEOUT_CYCLES
  // cycles in total.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [7:0]  wait_q, wait_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] faddr_q, faddr_d;
  logic        launch;
  logic [7:0]  wait_inc;

  assign wait_inc = wait_q + 8'd1;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    wait_d  = wait_q;
    // Fault report is cleared by default so it reads 0 outside FAULT.
    cause_d = CAUSE_NONE;
    faddr_d = '0;
    launch  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        launch = fetchStart;
      end

      S_REQUEST: begin
        if (memReady) begin
          if (memError) begin
            state_d = S_FAULT;
            cause_d = CAUSE_ACCESS;
            faddr_d = addr_q;
          end else begin
            instr_d = memReadData;
            state_d = S_HOLD;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == TIMEOUT_LIMIT) begin
            state_d = S_FAULT;
            cause_d = CAUSE_TIMEOUT;
            faddr_d = addr_q;
          end
        end
      end

      S_HOLD: begin
        // fetchStart only counts together with acceptance of the held word.
        if (instructionReady) begin
          state_d = S_IDLE;
          launch  = fetchStart;
        end
      end

      S_FAULT: begin
        cause_d = cause_q;
        faddr_d = faddr_q;
        // A new fetch clears the fault and is handled as if from IDLE.
        launch  = fetchStart;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Shared fetch launch, reached from IDLE, FAULT and accepted HOLD.
    if (launch) begin
      if (pcOfInstruction[1:0] == 2'b00) begin
        state_d = S_REQUEST;
        addr_d  = pcOfInstruction;
        wait_d  = 8'd0;
        cause_d = CAUSE_NONE;
        faddr_d = '0;
      end else begin
        state_d = S_FAULT;
        cause_d = CAUSE_MISALIGN;
        faddr_d = pcOfInstruction;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      instr_q <= RESET_INSTRUCTION;
      wait_q  <= 8'd0;
      cause_q <= CAUSE_NONE;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      faddr_q <= faddr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: registers or state decodes only
  // -------------------------------------------------------------------------
  assign memAddress       = addr_q;
  assign memRequest       = (state_q == S_REQUEST);
  assign instruction      = instr_q;
  assign instructionValid = (state_q == S_HOLD);
  assign busy             = (state_q == S_REQUEST) || (state_q == S_HOLD);
  assign fault            = (state_q == S_FAULT);
  assign faultCause       = cause_q;
  assign faultAddress     = faddr_q;

endmodule
